// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester round-robin APB master
// Optional abort of stalled transfers: define APB_MASTER_ARB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_done,
  output logic [31:0]       req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_done,
  output logic [31:0]       req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   pick;
  logic   timeout_hit;
  logic   finish;

  // On a tie the requester that was not served last wins.
  assign pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state      <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            state      <= SETUP;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            grant      <= pick;
            last_grant <= pick;
            PWRITE     <= pick ? req1_write : req0_write;
            PADDR      <= pick ? req1_addr  : req0_addr;
            PWDATA     <= pick ? req1_wdata : req0_wdata;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tcnt;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tcnt <= '0;
    end else if (state == SETUP) begin
      tcnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // The cycle in which the count sits at TIMEOUT-1 is itself the last wait cycle.
  assign timeout_hit = (state == ACCESS) && !PREADY && (tcnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  assign finish     = (state == ACCESS) && (PREADY || timeout_hit);
  assign req0_done  = finish && !grant;
  assign req1_done  = finish &&  grant;
  assign req0_rdata = (req0_done && PREADY) ? PRDATA : 32'h0;
  assign req1_rdata = (req1_done && PREADY) ? PRDATA : 32'h0;
  // An abort is the only way to finish with PREADY low.
  assign req0_err   = req0_done && !PREADY;
  assign req1_err   = req1_done && !PREADY;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - directed self-checking bench for apb_master_arb
// Timeout scenario follows APB_MASTER_ARB_TIMEOUT_EN.
module tb_apb_master_arb;

  localparam int ADDR_W = 3;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              req0_valid, req0_write, req1_valid, req1_write;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [31:0]       req0_wdata, req1_wdata;
  logic              req0_done, req1_done, req0_err, req1_err;
  logic [31:0]       req0_rdata, req1_rdata;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE, PSEL, PENABLE, PREADY;
  logic [31:0]       PWDATA, PRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  apb_master_arb #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESET = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    #2;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_done", {req1_done, req0_done}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    step(); step();

    // Single write from req0
    PRESET = 1'b1;
    req0_valid = 1; req0_write = 1; req0_addr = 3'd0; req0_wdata = 32'hF; PREADY = 1;
    step();
    chk("wr_setup_psel", {PSEL, PENABLE}, 2'b10);
    chk("wr_setup_paddr", PADDR, 0);
    chk("wr_setup_pwdata", PWDATA, 32'hF);
    chk("wr_setup_pwrite", PWRITE, 1);
    chk("wr_setup_nodone", {req1_done, req0_done}, 0);
    step();
    chk("wr_access", {PSEL, PENABLE}, 2'b11);
    chk("wr_done", {req1_done, req0_done}, 2'b01);
    chk("wr_err", req0_err, 0);
    req0_valid = 0;
    step();
    chk("wr_idle", {PSEL, PENABLE, req0_done}, 0);

    // Round-robin after a fresh reset: req0 wins the first tie
    PRESET = 0; #1; PRESET = 1;
    req0_valid = 1; req0_write = 1; req0_addr = 3'd1; req0_wdata = 32'h100;
    req1_valid = 1; req1_write = 1; req1_addr = 3'd2; req1_wdata = 32'h200;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_paddr", PADDR, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_pwdata", PWDATA, (i % 2 == 0) ? 32'h100 : 32'h200);
      step();
      chk("rr_done", {req1_done, req0_done}, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("rr_idle", PSEL, 0);
    end

    // Wait states on a req1 read
    req0_valid = 0;
    req1_write = 0; req1_addr = 3'd4; PREADY = 0; PRDATA = 32'hA5;
    step();
    chk("ws_setup_paddr", PADDR, 4);
    chk("ws_setup_pwrite", PWRITE, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("ws_hold", {PSEL, PENABLE, 1'b0, PADDR}, {2'b11, 1'b0, 3'd4});
      chk("ws_nodone", {req1_done, req0_done}, 0);
      if (i < 4) step();
    end
    PREADY = 1; #1;
    chk("ws_done", {req1_done, req0_done}, 2'b10);
    chk("ws_rdata1", req1_rdata, 32'hA5);
    chk("ws_rdata0", req0_rdata, 0);
    chk("ws_err", req1_err, 0);
    req1_valid = 0;
    step();
    chk("ws_idle", PSEL, 0);

    // Stalled req0 read
    req0_valid = 1; req0_write = 0; req0_addr = 3'd3; PREADY = 0; PRDATA = 32'hDEAD;
    step();
    step();
`ifdef APB_MASTER_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      chk("to_wait", {PSEL, PENABLE, req0_done}, 3'b110);
      step();
    end
    chk("to_done", {req1_done, req0_done}, 2'b01);
    chk("to_err", req0_err, 1);
    chk("to_rdata", req0_rdata, 0);
    req0_valid = 0;
    step();
    chk("to_idle", {PSEL, PENABLE}, 0);
`else
    for (int i = 1; i < 40; i++) begin
      chk("noto_hold", {PSEL, PENABLE, req0_done, req0_err}, 4'b1100);
      step();
    end
    PREADY = 1; #1;
    chk("noto_done", {req0_done, req0_err}, 2'b10);
    chk("noto_rdata", req0_rdata, 32'hDEAD);
    req0_valid = 0;
    step();
    chk("noto_idle", PSEL, 0);
`endif

    // Reset in the middle of ACCESS
    req1_valid = 1; req1_write = 1; req1_addr = 3'd5; req1_wdata = 32'h55; PREADY = 0;
    step(); step(); step();
    chk("mid_access", {PSEL, PENABLE}, 2'b11);
    #2;
    PRESET = 0; #1;
    chk("mid_rst_psel", {PSEL, PENABLE}, 0);
    chk("mid_rst_done", {req1_done, req0_done}, 0);
    PREADY = 1; #1;
    chk("mid_rst_done_rdy", {req1_done, req0_done}, 0);
    step();
    chk("mid_rst_held", {PSEL, req1_done}, 0);
    PRESET = 1; PREADY = 0;
    step();
    chk("post_setup", {PSEL, PENABLE}, 2'b10);
    chk("post_paddr", PADDR, 5);
    chk("post_pwdata", PWDATA, 32'h55);
    PREADY = 1;
    step();
    chk("post_done", {req1_done, req0_done, req1_err}, 3'b100);
    req1_valid = 0;
    step();
    chk("post_idle", {PSEL, req1_done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter ADDR_W, default 3, width of PADDR and of the requester address fields.
REQ-002 Parameter TIMEOUT, default 16, number of ACCESS cycles without PREADY before an abort; used only when the timeout feature is compiled in.
REQ-003 Port PCLK, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 Port PRESET, input, 1 bit, asynchronous active-low reset.
REQ-005 Ports req0_valid / req1_valid, input, 1 bit each, requester n has a transfer pending.
REQ-006 Ports req0_write / req1_write, input, 1 bit each, 1 = write, 0 = read.
REQ-007 Ports req0_addr / req1_addr, input, ADDR_W bits each, target address.
REQ-008 Ports req0_wdata / req1_wdata, input, 32 bits each, write data.
REQ-009 Ports req0_done / req1_done, output, 1 bit each, one-cycle transfer-complete strobe.
REQ-010 Ports req0_rdata / req1_rdata, output, 32 bits each, read data, valid while done is high.
REQ-011 Ports req0_err / req1_err, output, 1 bit each, transfer aborted; qualified by done.
REQ-012 APB master ports: PADDR (output, ADDR_W), PWRITE (output, 1), PSEL (output, 1), PENABLE (output, 1), PWDATA (output, 32), PRDATA (input, 32), PREADY (input, 1).

Function
REQ-013 FSM states are IDLE, SETUP and ACCESS.
- IDLE -> SETUP when any valid is high.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE when PREADY is high, or on timeout.
REQ-014 Output encoding per state: IDLE drives PSEL=0, PENABLE=0; SETUP drives PSEL=1, PENABLE=0; ACCESS drives PSEL=1, PENABLE=1.
REQ-015 Arbitration happens only in IDLE and is round-robin.
- One valid high: that requester is granted.
- Both valid high: the requester not granted last is granted.
- last_grant updates on each grant.
REQ-016 On the IDLE->SETUP edge the granted requester's write, addr and wdata are registered into PWRITE, PADDR and PWDATA. They are held constant through SETUP and ACCESS.
REQ-017 done_n = (state==ACCESS) && PREADY && (grant==n), combinational. rdata_n = PRDATA when done_n, else 0. err_n = 0 on a normal completion.
REQ-018 Requester handshake:
- The requester holds valid, write, addr and wdata stable until its done.
- It may drop valid or present a new request at the edge following done.
- Changes to a non-granted requester's inputs do not affect the transfer in flight.
REQ-019 Minimum latency is 3 cycles per transfer (IDLE, SETUP, ACCESS with PREADY=1). Every transfer returns through IDLE, so back-to-back transfers take 3 cycles each.
REQ-020 Wait states: ACCESS is held with all APB outputs stable while PREADY=0.
REQ-021 At most one done is high in any cycle, and done never asserts outside ACCESS.

Reset
REQ-022 PRESET low immediately, without waiting for a clock edge, forces:
- state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- last_grant=1, so req0 wins the first tie;
- timeout counter=0, all done and err outputs 0.
REQ-023 A reset asserted mid-transfer abandons the transfer with no done. After PRESET rises, arbitration restarts from IDLE on the next edge.

Configuration
REQ-024 Macro APB_MASTER_ARB_TIMEOUT_EN controls the timeout feature.
- Defined: a counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0.
- When the counter reaches TIMEOUT-1 with PREADY=0: done_n=1, err_n=1 and rdata_n=0 for the granted requester, then state goes to IDLE.
- PREADY=1 in that same cycle takes priority: a normal completion with err=0.
REQ-025 Without APB_MASTER_ARB_TIMEOUT_EN, ACCESS waits for PREADY indefinitely. The err ports still exist and are tied to 0.

Verification
REQ-026 The bench covers these directed scenarios:
- Reset: PRESET=0 -> PSEL=0, PENABLE=0, all done=0. PRESET released, req0 writes addr 0 data 0xF with PREADY=1 -> SETUP with PADDR=0, PWDATA=0xF, PWRITE=1, then ACCESS, then req0_done for 1 cycle, err=0.
- Round-robin: both valid, four transfers each -> grant order 0,1,0,1,... with no requester starved.
- Wait states: req1 reads addr 4, PREADY low for 5 cycles then high with PRDATA=0xA5 -> PSEL, PENABLE and PADDR stable for all 5 wait cycles, then req1_done=1 with req1_rdata=0xA5.
- Timeout (macro defined, TIMEOUT=16): PREADY held 0 -> after 16 ACCESS cycles req0_done=1, req0_err=1, state returns to IDLE. Without the macro, PSEL stays 1 indefinitely.
- Reset mid-ACCESS: PRESET pulsed low -> PSEL and PENABLE fall without waiting for a clock edge, no done is issued, and the next request is served normally.
